// File: rtl/sd_digit_streamer_pkg.sv
// Shared definitions for the signed-digit word-to-digit streamer:
// digit encodings, word geometry and the control state enum.
package sd_digit_streamer_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  localparam int DIGITS_PER_WORD = 4;
  localparam int NIBBLE_W        = 4;
  localparam int WORD_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Nonzero test used when inspecting digits; 2'b11 counts as zero.
  function automatic logic sd_is_nonzero(input logic [1:0] d);
    return (d == SD_POS) || (d == SD_NEG);
  endfunction

endpackage

// File: rtl/sd_word_fifo2.sv
// Two-entry word FIFO feeding the digit mux; the head word is exposed
// directly so the top can select nibbles from it with no extra latency.
module sd_word_fifo2
  import sd_digit_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem0_q, mem0_d;
  logic [WORD_W-1:0] mem1_q, mem1_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);

    if (do_push) begin
      if (wr_ptr_q) mem1_d = push_data;
      else          mem0_d = push_data;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = rd_ptr_q ? mem1_q : mem0_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/sd_digit_streamer.sv
// Unpacks 16-bit words of four SD x/y digit pairs into a digit-per-cycle
// stream (nibble 0 first), then appends PAD_DIGITS zero pairs for flushing.
module sd_digit_streamer
  import sd_digit_streamer_pkg::*;
#(
  parameter int MAX_WORDS  = 32,
  parameter int PAD_DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        num_words,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        x_digit,
  output logic [1:0]        y_digit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [$clog2(DIGITS_PER_WORD*MAX_WORDS)-1:0] cnt,
  output logic [4:0]        computation_cycles,
  output logic              out_pad,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DIGITS_PER_WORD * MAX_WORDS);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid never depends on ready, and the registered view
  // (digits, cnt, flags) only changes after a completed transfer.

  state_e            state_q, state_d;
  logic [4:0]        num_words_q, num_words_d;
  logic [4:0]        accepted_q, accepted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        cc_q, cc_d;
  logic [1:0]        p_q, p_d;

  logic [WORD_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [NIBBLE_W-1:0] nibble;
  logic                out_hs;
  logic                digit_last;
  logic                word_last;

  assign nibble     = fifo_head[{p_q, 2'b00} +: NIBBLE_W];
  assign digit_last = (p_q == 2'(DIGITS_PER_WORD - 1));
  assign word_last  = (cc_q == (num_words_q - 5'd1));
  assign out_hs     = out_valid && out_ready;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = (state_q == ST_STREAM) && out_hs && digit_last;

  sd_word_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_word),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    x_digit   = SD_ZERO;
    y_digit   = SD_ZERO;
    out_pad   = 1'b0;
    last      = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    cnt       = cnt_q;
    computation_cycles = cc_q;

    case (state_q)
      ST_STREAM: begin
        in_ready  = !fifo_full && (accepted_q < num_words_q);
        out_valid = !fifo_empty;
        if (!fifo_empty) begin
          x_digit = nibble[3:2];
          y_digit = nibble[1:0];
          last    = (PAD_DIGITS == 0) && digit_last && word_last;
        end
      end
      ST_PAD: begin
        out_valid = 1'b1;
        out_pad   = 1'b1;
        last      = (cnt_q == CNT_W'(PAD_DIGITS - 1));
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    accepted_d  = accepted_q;
    cnt_d       = cnt_q;
    cc_d        = cc_q;
    p_d         = p_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (num_words != 5'd0)) begin
          state_d     = ST_STREAM;
          num_words_d = num_words;
          accepted_d  = 5'd0;
          cnt_d       = '0;
          cc_d        = 5'd0;
          p_d         = 2'd0;
        end
      end
      ST_STREAM: begin
        if (fifo_push) accepted_d = accepted_q + 5'd1;
        if (out_hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          p_d   = p_q + 2'd1;
          if (digit_last) begin
            // The final word leaves computation_cycles at num_words-1.
            if (word_last) begin
              if (PAD_DIGITS > 0) begin
                state_d = ST_PAD;
                cnt_d   = '0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              cc_d = cc_q + 5'd1;
            end
          end
        end
      end
      ST_PAD: begin
        if (out_hs) begin
          if (cnt_q == CNT_W'(PAD_DIGITS - 1)) state_d = ST_DONE;
          else                                 cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_words_q <= 5'd0;
      accepted_q  <= 5'd0;
      cnt_q       <= '0;
      cc_q        <= 5'd0;
      p_q         <= 2'd0;
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      accepted_q  <= accepted_d;
      cnt_q       <= cnt_d;
      cc_q        <= cc_d;
      p_q         <= p_d;
    end
  end

endmodule

// File: tb/tb_sd_digit_streamer.sv
// Directed bench for sd_digit_streamer: a PAD_DIGITS=2 instance for most
// scenarios and a PAD_DIGITS=0 instance for the no-padding last flag.
module tb_sd_digit_streamer;

  localparam int TB_PAD = 2;
  localparam int DW     = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // PAD_DIGITS = 2 instance
  logic        start;
  logic [4:0]  num_words;
  logic [15:0] in_word;
  logic        in_valid, in_ready;
  logic [1:0]  x_digit, y_digit;
  logic        out_valid, out_ready;
  logic [6:0]  cnt;
  logic [4:0]  computation_cycles;
  logic        out_pad, last, busy, done;

  // PAD_DIGITS = 0 instance
  logic        start0;
  logic [4:0]  num_words0;
  logic [15:0] in_word0;
  logic        in_valid0, in_ready_0;
  logic [1:0]  x_digit_0, y_digit_0;
  logic        out_valid_0, out_ready0;
  logic [6:0]  cnt_0;
  logic [4:0]  cc_0;
  logic        out_pad_0, last_0, busy_0, done_0;

  sd_digit_streamer #(.MAX_WORDS(32), .PAD_DIGITS(TB_PAD)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .x_digit(x_digit), .y_digit(y_digit), .out_valid(out_valid),
    .out_ready(out_ready), .cnt(cnt), .computation_cycles(computation_cycles),
    .out_pad(out_pad), .last(last), .busy(busy), .done(done)
  );

  sd_digit_streamer #(.MAX_WORDS(32), .PAD_DIGITS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_words(num_words0),
    .in_word(in_word0), .in_valid(in_valid0), .in_ready(in_ready_0),
    .x_digit(x_digit_0), .y_digit(y_digit_0), .out_valid(out_valid_0),
    .out_ready(out_ready0), .cnt(cnt_0), .computation_cycles(cc_0),
    .out_pad(out_pad_0), .last(last_0), .busy(busy_0), .done(done_0)
  );

  int checks = 0;
  int passed = 0;

  // Scoreboard: digit records are {x, y, cnt, cc, pad, last}.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic [15:0]   src_words[32];
  logic [3:0]    rdy_pat;

  int first_push_cyc, first_valid_cyc, last_dig_cyc, done_cyc;
  int hold_viol, stall_cycles, bubbles;
  bit saw_full;

  function automatic logic [DW-1:0] pk(input logic [1:0] x, input logic [1:0] y,
                                       input logic [6:0] c, input logic [4:0] cc,
                                       input logic pad, input logic lst);
    return {x, y, c, cc, pad, lst};
  endfunction

  function automatic logic [DW-1:0] cur_dig();
    return {x_digit, y_digit, cnt, computation_cycles, out_pad, last};
  endfunction

  // Reference digit sequence for n words from src_words plus TB_PAD pads.
  task automatic build_exp(input int n);
    logic [15:0] wd;
    logic [3:0]  nib;
    exp_q.delete();
    for (int w = 0; w < n; w++) begin
      wd = src_words[w];
      for (int k = 0; k < 4; k++) begin
        nib = wd[4*k +: 4];
        exp_q.push_back(pk(nib[3:2], nib[1:0], 7'(4*w + k), 5'(w), 1'b0, 1'b0));
      end
    end
    for (int j = 0; j < TB_PAD; j++)
      exp_q.push_back(pk(2'b00, 2'b00, 7'(j), 5'(n - 1), 1'b1, j == TB_PAD - 1));
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start     = 1'b1;
    num_words = 5'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Source/sink driver: feeds src_words[0..n-1], applies rdy_pat to
  // out_ready, records every digit handshake and timing landmarks.
  task automatic run_xfer(input int n, input int stop_after, input int restart_cyc,
                          output bit timed_out);
    int wi;
    bit prev_stall;
    logic [DW-1:0] held, cur;
    obs_q.delete();
    first_push_cyc = -1; first_valid_cyc = -1; last_dig_cyc = -1; done_cyc = -1;
    hold_viol = 0; stall_cycles = 0; bubbles = 0; saw_full = 0;
    wi = 0; prev_stall = 0; held = '0; timed_out = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) num_words = 5'd5;
      in_valid  = (wi < n);
      in_word   = (wi < n) ? src_words[wi] : 16'h0000;
      out_ready = rdy_pat[cyc % 4];
      #1;
      cur = cur_dig();
      if (prev_stall && (!out_valid || cur !== held)) hold_viol++;
      if (done) begin
        done_cyc  = cyc;
        timed_out = 0;
        return;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (first_valid_cyc >= 0 && !out_valid) bubbles++;
      if (busy && !out_pad && in_valid && !in_ready) saw_full = 1;
      if (in_valid && in_ready) begin
        if (first_push_cyc < 0) first_push_cyc = cyc;
        wi++;
      end
      if (out_valid && out_ready) begin
        obs_q.push_back(cur);
        last_dig_cyc = cyc;
        if (obs_q.size() == stop_after) begin
          timed_out = 0;
          @(posedge clk);
          #2;
          return;
        end
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cycles++;
      held = cur;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({in_ready, out_valid, busy, done, out_pad, last, x_digit, y_digit, cnt, computation_cycles} !== 22'd0)
      $display("FAIL reset_outputs got in_ready=%b out_valid=%b busy=%b done=%b cnt=%0d cc=%0d expected all zero",
               in_ready, out_valid, busy, done, cnt, computation_cycles);
    else passed++;
    checks++;
    if ({in_ready_0, out_valid_0, busy_0, done_0, out_pad_0, last_0, x_digit_0, y_digit_0, cnt_0, cc_0} !== 22'd0)
      $display("FAIL reset_outputs_pad0 got busy=%b out_valid=%b cnt=%0d expected all zero", busy_0, out_valid_0, cnt_0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL idle_after_reset got busy=%b in_ready=%b out_valid=%b expected 0 0 0", busy, in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_single_word();
    bit to;
    src_words[0] = 16'h4321;
    rdy_pat = 4'b1111;
    exp_q.delete();
    exp_q.push_back(pk(2'b00, 2'b01, 7'd0, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(pk(2'b00, 2'b10, 7'd1, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(pk(2'b00, 2'b11, 7'd2, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(pk(2'b01, 2'b00, 7'd3, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(pk(2'b00, 2'b00, 7'd0, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(pk(2'b00, 2'b00, 7'd1, 5'd0, 1'b1, 1'b1));
    do_start(1);
    run_xfer(1, -1, -1, to);
    checks++;
    if (to) $display("FAIL single_timeout got no done within budget expected done");
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL single_count got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [DW-1:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL single_digit[%0d] got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
    checks++;
    if (first_valid_cyc - first_push_cyc != 1)
      $display("FAIL single_latency got %0d expected 1", first_valid_cyc - first_push_cyc);
    else passed++;
    checks++;
    if (done_cyc - last_dig_cyc != 1)
      $display("FAIL single_done_delay got %0d expected 1", done_cyc - last_dig_cyc);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL single_back_to_idle got busy=%b done=%b expected 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit to;
    src_words[0] = 16'h8888; src_words[1] = 16'h4444; src_words[2] = 16'h9999;
    rdy_pat = 4'b1111;
    build_exp(3);
    do_start(3);
    run_xfer(3, -1, -1, to);
    checks++;
    if (to) $display("FAIL b2b_timeout got no done expected done");
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL b2b_count got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [DW-1:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL b2b_digit[%0d] got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
    checks++;
    if (bubbles != 0 || last_dig_cyc - first_valid_cyc != 13)
      $display("FAIL b2b_no_bubble got bubbles=%0d span=%0d expected 0 and 13", bubbles, last_dig_cyc - first_valid_cyc);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit to;
    src_words[0] = 16'h1234; src_words[1] = 16'h5678; src_words[2] = 16'h9ABC;
    rdy_pat = 4'b1001;
    build_exp(3);
    do_start(3);
    run_xfer(3, -1, -1, to);
    checks++;
    if (to) $display("FAIL bp_timeout got no done expected done");
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL bp_count got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [DW-1:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL bp_digit[%0d] got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
    checks++;
    if (hold_viol != 0 || stall_cycles == 0)
      $display("FAIL bp_hold got violations=%0d stalls=%0d expected 0 and >0", hold_viol, stall_cycles);
    else passed++;
    checks++;
    if (!saw_full) $display("FAIL bp_in_ready_drop got in_ready never low expected low with 2 words buffered");
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit to;
    src_words[0] = 16'h2468; src_words[1] = 16'h1357; src_words[2] = 16'hFACE;
    rdy_pat = 4'b1111;
    do_start(3);
    run_xfer(3, 6, -1, to);
    checks++;
    if (to || busy !== 1'b1) $display("FAIL rstmid_setup got timeout=%0d busy=%b expected 0 1", to, busy);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, out_pad, last, x_digit, y_digit, cnt, computation_cycles} !== 22'd0)
      $display("FAIL rstmid_async got busy=%b out_valid=%b cnt=%0d cc=%0d expected all zero", busy, out_valid, cnt, computation_cycles);
    else passed++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) $display("FAIL rstmid_no_done got done=%b expected 0", done);
      else passed++;
    end
    rst = 1'b0;
    src_words[0] = 16'h4321;
    do_start(1);
    run_xfer(1, -1, -1, to);
    checks++;
    if (to || obs_q.size() != 6) $display("FAIL rstmid_restart_count got %0d expected 6", obs_q.size());
    else passed++;
    checks++;
    if (obs_q.size() == 0 || obs_q[0] !== pk(2'b00, 2'b01, 7'd0, 5'd0, 1'b0, 1'b0))
      $display("FAIL rstmid_restart_first got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : '0,
               pk(2'b00, 2'b01, 7'd0, 5'd0, 1'b0, 1'b0));
    else passed++;
  endtask

  task automatic test_zero_words();
    do_start(0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL zero_words got busy=%b out_valid=%b in_ready=%b expected 0 0 0", busy, out_valid, in_ready);
      else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    src_words[0] = 16'hA5C3; src_words[1] = 16'h0F0F;
    rdy_pat = 4'b1111;
    build_exp(2);
    do_start(2);
    run_xfer(2, -1, 3, to);
    checks++;
    if (to || obs_q.size() != exp_q.size())
      $display("FAIL busy_start_count got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [DW-1:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL busy_start_digit[%0d] got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle got busy=%b expected 0", busy);
    else passed++;
  endtask

  // The 5-bit num_words port tops out at 31 words, so cnt peaks at 123.
  task automatic test_max_words();
    bit to;
    logic [DW-1:0] got;
    for (int w = 0; w < 31; w++) src_words[w] = 16'h1B4E ^ 16'(w * 16'h0111);
    rdy_pat = 4'b1111;
    build_exp(31);
    do_start(31);
    run_xfer(31, -1, -1, to);
    checks++;
    if (to || obs_q.size() != exp_q.size())
      $display("FAIL max_count got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL max_digit[%0d] got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
    got = (obs_q.size() > 123) ? obs_q[123] : '0;
    checks++;
    if (got[13:7] !== 7'd123 || got[6:2] !== 5'd30)
      $display("FAIL max_final_cnt got cnt=%0d cc=%0d expected 123 30", got[13:7], got[6:2]);
    else passed++;
  endtask

  task automatic test_pad_zero();
    logic [4:0] obs0[$];
    logic [4:0] exp0[4];
    int last_cyc, dn_cyc;
    bit drop;
    exp0[0] = {2'b00, 2'b01, 1'b0};
    exp0[1] = {2'b10, 2'b11, 1'b0};
    exp0[2] = {2'b01, 2'b00, 1'b0};
    exp0[3] = {2'b11, 2'b10, 1'b1};
    last_cyc = -1; dn_cyc = -1; drop = 0;
    @(negedge clk);
    start0 = 1'b1; num_words0 = 5'd1; in_word0 = 16'hE4B1; in_valid0 = 1'b1; out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (drop) in_valid0 = 1'b0;
      #1;
      if (done_0) begin
        dn_cyc = c;
        break;
      end
      if (in_valid0 && in_ready_0) drop = 1;
      if (out_valid_0 && out_ready0) begin
        obs0.push_back({x_digit_0, y_digit_0, last_0});
        last_cyc = c;
      end
    end
    checks++;
    if (obs0.size() != 4) $display("FAIL pad0_count got %0d expected 4", obs0.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] got;
      got = (i < obs0.size()) ? obs0[i] : 'x;
      checks++;
      if (got !== exp0[i]) $display("FAIL pad0_digit[%0d] got %b expected %b", i, got, exp0[i]);
      else passed++;
    end
    checks++;
    if (dn_cyc < 0 || dn_cyc != last_cyc + 1)
      $display("FAIL pad0_done got cycle %0d expected %0d", dn_cyc, last_cyc + 1);
    else passed++;
  endtask

  initial begin
    start = 0; num_words = '0; in_word = '0; in_valid = 0; out_ready = 0;
    start0 = 0; num_words0 = '0; in_word0 = '0; in_valid0 = 0; out_ready0 = 0;
    rdy_pat = 4'b1111;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_zero_words();
    test_start_while_busy();
    test_max_words();
    test_pad_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
